// File: rtl/trg_tx_link_seq.sv
// -----------------------------------------------------------------------------
// trg_tx_link_seq
//
// Bring-up and recovery sequencer for the DCFEB trigger fiber transmitter.
// It steps the TX PLL reset, the GTX TX reset and the link-level TRG_RST
// (comma/idle) of the fiber-out block in order. At each step it waits for PLL
// lock, TX reset done and TX phase-sync done. Timeouts and loss of lock
// trigger a bounded number of retries before the sequencer parks in FAIL.
// Everything runs on TRG_CLK80.
//
// Ports:
//   TRG_CLK80        in   sole clock, rising edge
//   RST_N            in   synchronous active-low reset
//   LINK_EN          in   level: 1 requests link up, 0 forces OFF
//   TRG_TX_PLL_LOCK  in   async GTX PLL lock status (synchronized here)
//   TRG_TXRESETDONE  in   async GTX TX reset-done status (synchronized here)
//   TX_SYNC_DONE     in   async TX phase-align done status (synchronized here)
//   TRG_TX_PLLRST    out  TX PLL reset, active-high
//   TRG_GTXTXRST     out  GTX TX reset, active-high
//   TRG_RST          out  link reset; while 1 the transmitter sends commas
//   LINK_UP          out  1 only in UP
//   FAIL             out  1 only in FAIL
//   STATE            out  current state code (4 bits)
//   RETRY_CNT        out  retries since reset, saturating at 255
// -----------------------------------------------------------------------------
module trg_tx_link_seq #(
   parameter int SIM_SPEEDUP = 0,
   parameter int PLLRST_CYC  = 16,
   parameter int GTXRST_CYC  = 16,
   parameter int TMO_CYC     = 50000,
   parameter int IDLE_CYC    = 256,
   parameter int MAX_RETRY   = 4
) (
   input  logic       TRG_CLK80,
   input  logic       RST_N,
   input  logic       LINK_EN,
   input  logic       TRG_TX_PLL_LOCK,
   input  logic       TRG_TXRESETDONE,
   input  logic       TX_SYNC_DONE,
   output logic       TRG_TX_PLLRST,
   output logic       TRG_GTXTXRST,
   output logic       TRG_RST,
   output logic       LINK_UP,
   output logic       FAIL,
   output logic [3:0] STATE,
   output logic [7:0] RETRY_CNT
);

   // State codes are visible on STATE, so they are fixed values.
   localparam logic [3:0] ST_OFF       = 4'd0;
   localparam logic [3:0] ST_PLL_RST   = 4'd1;
   localparam logic [3:0] ST_PLL_WAIT  = 4'd2;
   localparam logic [3:0] ST_GTX_RST   = 4'd3;
   localparam logic [3:0] ST_DONE_WAIT = 4'd4;
   localparam logic [3:0] ST_SYNC_WAIT = 4'd5;
   localparam logic [3:0] ST_COMMA     = 4'd6;
   localparam logic [3:0] ST_UP        = 4'd7;
   localparam logic [3:0] ST_FAIL      = 4'd8;

   // Terminal timer values: a state that lasts N cycles leaves on the edge
   // where the timer, cleared on entry, reads N-1.
   localparam logic [15:0] PLLRST_LAST = 16'(PLLRST_CYC - 1);
   localparam logic [15:0] GTXRST_LAST = 16'(GTXRST_CYC - 1);
   localparam logic [15:0] TMO_LAST    = (SIM_SPEEDUP != 0) ? 16'd63 : 16'(TMO_CYC - 1);
   localparam logic [15:0] IDLE_LAST   = (SIM_SPEEDUP != 0) ? 16'd63 : 16'(IDLE_CYC - 1);
   // A retry taken while the try counter already holds MAX_RETRY-1 is the
   // MAX_RETRY-th one and ends in FAIL.
   localparam logic [3:0]  TRY_LIMIT   = 4'(MAX_RETRY - 1);

   // Output decode {pllrst, gtxrst, trg_rst, link_up, fail} for a state.
   function automatic logic [4:0] decode_outs(input logic [3:0] st);
      logic [4:0] o;
      case (st)
         ST_OFF,
         ST_PLL_RST:   o = 5'b11100;
         ST_PLL_WAIT,
         ST_GTX_RST:   o = 5'b01100;
         ST_DONE_WAIT,
         ST_SYNC_WAIT,
         ST_COMMA:     o = 5'b00100;
         ST_UP:        o = 5'b00010;
         ST_FAIL:      o = 5'b11101;
         default:      o = 5'b11100;
      endcase
      return o;
   endfunction

   logic        lock_meta_q, lock_s_q;
   logic        done_meta_q, done_s_q;
   logic        sync_meta_q, sync_s_q;

   logic [3:0]  state_q, state_d;
   logic [3:0]  fwd_d;
   logic        retry_req;
   logic        retry_take;
   logic [15:0] timer_q, timer_d;
   logic [3:0]  try_q, try_d;
   logic [7:0]  retry_cnt_q, retry_cnt_d;
   logic [4:0]  outs_q, outs_d;

   // Two-flop synchronizers for the three asynchronous status inputs.
   always_ff @(posedge TRG_CLK80) begin
      if (!RST_N) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         done_meta_q <= 1'b0;
         done_s_q    <= 1'b0;
         sync_meta_q <= 1'b0;
         sync_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= TRG_TX_PLL_LOCK;
         lock_s_q    <= lock_meta_q;
         done_meta_q <= TRG_TXRESETDONE;
         done_s_q    <= done_meta_q;
         sync_meta_q <= TX_SYNC_DONE;
         sync_s_q    <= sync_meta_q;
      end
   end

   // Per-state forward progress and retry requests.
   always_comb begin
      fwd_d     = state_q;
      retry_req = 1'b0;
      case (state_q)
         ST_OFF: begin
            if (LINK_EN) fwd_d = ST_PLL_RST;
            else         fwd_d = ST_OFF;
         end
         ST_PLL_RST: begin
            if (timer_q == PLLRST_LAST) fwd_d = ST_PLL_WAIT;
            else                        fwd_d = ST_PLL_RST;
         end
         ST_PLL_WAIT: begin
            if (lock_s_q)                  fwd_d = ST_GTX_RST;
            else if (timer_q == TMO_LAST)  retry_req = 1'b1;
            else                           fwd_d = ST_PLL_WAIT;
         end
         ST_GTX_RST: begin
            if (!lock_s_q)                   retry_req = 1'b1;
            else if (timer_q == GTXRST_LAST) fwd_d = ST_DONE_WAIT;
            else                             fwd_d = ST_GTX_RST;
         end
         ST_DONE_WAIT: begin
            if (done_s_q)                  fwd_d = ST_SYNC_WAIT;
            else if (timer_q == TMO_LAST)  retry_req = 1'b1;
            else                           fwd_d = ST_DONE_WAIT;
         end
         ST_SYNC_WAIT: begin
            if (sync_s_q)                  fwd_d = ST_COMMA;
            else if (timer_q == TMO_LAST)  retry_req = 1'b1;
            else                           fwd_d = ST_SYNC_WAIT;
         end
         ST_COMMA: begin
            // Link health is checked before the idle-time exit so that a
            // loss on the final comma cycle still retries.
            if (!lock_s_q || !done_s_q)    retry_req = 1'b1;
            else if (timer_q == IDLE_LAST) fwd_d = ST_UP;
            else                           fwd_d = ST_COMMA;
         end
         ST_UP: begin
            if (!lock_s_q || !done_s_q) retry_req = 1'b1;
            else                        fwd_d = ST_UP;
         end
         ST_FAIL: begin
            fwd_d = ST_FAIL;
         end
         default: begin
            fwd_d = ST_OFF;
         end
      endcase
   end

   // Priority: LINK_EN low, then retry, then forward progress.
   always_comb begin
      retry_take = 1'b0;
      state_d    = fwd_d;
      if (!LINK_EN) begin
         state_d = ST_OFF;
      end else if (retry_req) begin
         retry_take = 1'b1;
         if (try_q >= TRY_LIMIT) state_d = ST_FAIL;
         else                    state_d = ST_PLL_RST;
      end else begin
         state_d = fwd_d;
      end
   end

   // Timer, try counter and retry counter next values.
   always_comb begin
      timer_d     = timer_q;
      try_d       = try_q;
      retry_cnt_d = retry_cnt_q;

      // Clears on any state change; holds at all-ones rather than wrapping
      // during long stays in UP so no stale terminal match can occur.
      if (state_d != state_q)       timer_d = 16'd0;
      else if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
      else                          timer_d = timer_q;

      if (state_q == ST_OFF)                  try_d = 4'd0;
      else if (retry_take && try_q != 4'hF)   try_d = try_q + 4'd1;
      else                                    try_d = try_q;

      if (retry_take && retry_cnt_q != 8'hFF) retry_cnt_d = retry_cnt_q + 8'd1;
      else                                    retry_cnt_d = retry_cnt_q;

      // Outputs come from the next state so they switch with STATE.
      outs_d = decode_outs(state_d);
   end

   // Sequencer state, counters and registered outputs.
   always_ff @(posedge TRG_CLK80) begin
      if (!RST_N) begin
         state_q     <= ST_OFF;
         timer_q     <= 16'd0;
         try_q       <= 4'd0;
         retry_cnt_q <= 8'd0;
         outs_q      <= 5'b11100;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         try_q       <= try_d;
         retry_cnt_q <= retry_cnt_d;
         outs_q      <= outs_d;
      end
   end

   assign TRG_TX_PLLRST = outs_q[4];
   assign TRG_GTXTXRST  = outs_q[3];
   assign TRG_RST       = outs_q[2];
   assign LINK_UP       = outs_q[1];
   assign FAIL          = outs_q[0];
   assign STATE         = state_q;
   assign RETRY_CNT     = retry_cnt_q;

endmodule

// File: tb/tb_trg_tx_link_seq.sv
// -----------------------------------------------------------------------------
// Self-checking bench for trg_tx_link_seq. Expected state transitions (state,
// edge number, retry count) are queued as stimulus is applied; a negedge
// monitor pops and compares them whenever STATE changes.
// A second instance with MAX_RETRY=15 and lock tied low covers RETRY_CNT
// saturation.
// -----------------------------------------------------------------------------
module tb_trg_tx_link_seq;

   localparam int P   = 4;    // PLLRST_CYC
   localparam int G   = 4;    // GTXRST_CYC
   localparam int TMO = 64;   // SIM_SPEEDUP timeout
   localparam int IDL = 64;   // SIM_SPEEDUP comma time

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, link_en, lock, done, sync;
   logic pllrst, gtxrst, trg_rst, link_up, fail;
   logic [3:0] state;
   logic [7:0] retry_cnt;

   logic sat_en, sat_zero;
   logic sat_pllrst, sat_gtxrst, sat_trg_rst, sat_link_up, sat_fail;
   logic [3:0] sat_state;
   logic [7:0] sat_rc;

   trg_tx_link_seq #(
      .SIM_SPEEDUP(1), .PLLRST_CYC(P), .GTXRST_CYC(G),
      .TMO_CYC(50000), .IDLE_CYC(256), .MAX_RETRY(2)
   ) u_dut (
      .TRG_CLK80(clk), .RST_N(rst_n), .LINK_EN(link_en),
      .TRG_TX_PLL_LOCK(lock), .TRG_TXRESETDONE(done), .TX_SYNC_DONE(sync),
      .TRG_TX_PLLRST(pllrst), .TRG_GTXTXRST(gtxrst), .TRG_RST(trg_rst),
      .LINK_UP(link_up), .FAIL(fail), .STATE(state), .RETRY_CNT(retry_cnt)
   );

   trg_tx_link_seq #(
      .SIM_SPEEDUP(1), .PLLRST_CYC(P), .GTXRST_CYC(G),
      .TMO_CYC(50000), .IDLE_CYC(256), .MAX_RETRY(15)
   ) u_sat (
      .TRG_CLK80(clk), .RST_N(rst_n), .LINK_EN(sat_en),
      .TRG_TX_PLL_LOCK(sat_zero), .TRG_TXRESETDONE(sat_zero), .TX_SYNC_DONE(sat_zero),
      .TRG_TX_PLLRST(sat_pllrst), .TRG_GTXTXRST(sat_gtxrst), .TRG_RST(sat_trg_rst),
      .LINK_UP(sat_link_up), .FAIL(sat_fail), .STATE(sat_state), .RETRY_CNT(sat_rc)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_retry = 0;

   typedef struct {
      int st;
      int cyc;
      int rc;
   } exp_t;
   exp_t exp_q[$];

   logic [3:0] prev_st;
   bit mon_en = 1'b0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected {pllrst, gtxrst, trg_rst, link_up, fail} from the state table.
   function automatic int outs_for(input int st);
      case (st)
         0, 1:    return 5'b11100;
         2, 3:    return 5'b01100;
         4, 5, 6: return 5'b00100;
         7:       return 5'b00010;
         8:       return 5'b11101;
         default: return 5'b11100;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Transition monitor: every STATE change must match the next expectation.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && state !== prev_st) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_transition", int'(state), int'(prev_st));
         end else begin
            e = exp_q.pop_front();
            check_eq("state", int'(state), e.st);
            check_eq("edge", cyc, e.cyc);
            check_eq("retry_cnt", int'(retry_cnt), e.rc);
            check_eq("outputs", int'({pllrst, gtxrst, trg_rst, link_up, fail}), outs_for(e.st));
         end
         prev_st = state;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto_edge(input int n);
      while (cyc < n) step();
   endtask

   task automatic push(input int st, input int c);
      exp_t e;
      e.st  = st;
      e.cyc = c;
      e.rc  = exp_retry;
      exp_q.push_back(e);
   endtask

   task automatic drain(input int budget);
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < budget) begin
         step();
         w++;
      end
      if (exp_q.size() != 0) begin
         check_eq("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0, d, a, b, e, c, f, g, h, w, want;
      rst_n = 1'b0; link_en = 1'b0; lock = 1'b0; done = 1'b0; sync = 1'b0;
      sat_en = 1'b0; sat_zero = 1'b0;
      repeat (3) step();

      // Reset values.
      check_eq("rst_state", int'(state), 0);
      check_eq("rst_pllrst", int'(pllrst), 1);
      check_eq("rst_gtxrst", int'(gtxrst), 1);
      check_eq("rst_trg_rst", int'(trg_rst), 1);
      check_eq("rst_link_up", int'(link_up), 0);
      check_eq("rst_fail", int'(fail), 0);
      check_eq("rst_retry", int'(retry_cnt), 0);
      rst_n = 1'b1;
      prev_st = 4'd0;
      mon_en = 1'b1;
      step();

      // Nominal bring-up: each status rises 10 cycles after its wait state.
      n0 = cyc; link_en = 1'b1; exp_retry = 0;
      push(1, n0 + 1);
      push(2, n0 + 1 + P);
      goto_edge(n0 + 1 + P + 10); lock = 1'b1;
      push(3, n0 + 1 + P + 13);
      push(4, n0 + 1 + P + 13 + G);
      goto_edge(n0 + 1 + P + 13 + G + 10); done = 1'b1;
      push(5, n0 + 1 + P + 26 + G);
      goto_edge(n0 + 1 + P + 26 + G + 10); sync = 1'b1;
      push(6, n0 + 1 + P + 39 + G);
      push(7, n0 + 1 + P + 39 + G + IDL);
      drain(300);
      check_eq("nom_link_up", int'(link_up), 1);
      check_eq("nom_trg_rst", int'(trg_rst), 0);
      check_eq("nom_retry", int'(retry_cnt), 0);

      // Lock loss in UP for 5 cycles.
      repeat (5) step();
      d = cyc; lock = 1'b0; exp_retry = 1;
      push(1, d + 3);
      goto_edge(d + 5); lock = 1'b1;
      push(2, d + 3 + P);          // lock_s is back on this same edge
      push(3, d + 4 + P);
      push(4, d + 4 + P + G);
      push(5, d + 5 + P + G);
      push(6, d + 6 + P + G);
      push(7, d + 6 + P + G + IDL);
      drain(300);
      check_eq("relock_link_up", int'(link_up), 1);

      // LINK_EN dropped mid-sequence in DONE_WAIT.
      a = cyc; link_en = 1'b0; done = 1'b0; sync = 1'b0;
      push(0, a + 1);
      goto_edge(a + 3);
      b = cyc; link_en = 1'b1;
      push(1, b + 1);
      push(2, b + 1 + P);
      push(3, b + 2 + P);
      push(4, b + 2 + P + G);
      goto_edge(b + 4 + P + G);
      check_eq("in_done_wait", int'(state), 4);
      e = cyc; link_en = 1'b0;
      push(0, e + 1);
      step();
      check_eq("drop_state", int'(state), 0);
      check_eq("drop_resets", int'({pllrst, gtxrst, trg_rst}), 3'b111);

      // Re-enable with lock absent: a cleared try counter gives exactly two
      // 64-cycle PLL_WAIT attempts before FAIL.
      goto_edge(e + 3);
      c = cyc; link_en = 1'b1; lock = 1'b0;
      push(1, c + 1);
      push(2, c + 1 + P);
      exp_retry = 2;
      push(1, c + 1 + P + TMO);
      push(2, c + 1 + 2 * P + TMO);
      exp_retry = 3;
      push(8, c + 1 + 2 * P + 2 * TMO);
      drain(400);
      repeat (3) step();
      check_eq("fail_hold", int'(fail), 1);
      check_eq("fail_resets", int'({pllrst, gtxrst, trg_rst}), 3'b111);
      f = cyc; link_en = 1'b0;
      push(0, f + 1);
      drain(10);

      // Bring up with all statuses already stable, then reset in UP.
      lock = 1'b1; done = 1'b1; sync = 1'b1;
      repeat (4) step();
      g = cyc; link_en = 1'b1;
      push(1, g + 1);
      push(2, g + 1 + P);
      push(3, g + 2 + P);
      push(4, g + 2 + P + G);
      push(5, g + 3 + P + G);
      push(6, g + 4 + P + G);
      push(7, g + 4 + P + G + IDL);
      drain(300);
      h = cyc; rst_n = 1'b0; link_en = 1'b0; exp_retry = 0;
      push(0, h + 1);
      step();
      check_eq("urst_state", int'(state), 0);
      check_eq("urst_resets", int'({pllrst, gtxrst, trg_rst}), 3'b111);
      check_eq("urst_link_up", int'(link_up), 0);
      check_eq("urst_fail", int'(fail), 0);
      check_eq("urst_retry", int'(retry_cnt), 0);
      rst_n = 1'b1;
      drain(5);

      // RETRY_CNT saturation: 20 enables x 15 retries = 300 retries.
      for (int k = 1; k <= 20; k++) begin
         sat_en = 1'b1;
         w = 0;
         while (!sat_fail && w < 2000) begin
            step();
            w++;
         end
         check_eq("sat_fail", int'(sat_fail), 1);
         want = (15 * k > 255) ? 255 : 15 * k;
         check_eq("sat_retry", int'(sat_rc), want);
         sat_en = 1'b0;
         step();
         check_eq("sat_off", int'(sat_state), 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
